// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder reused over WIDTH clocks to produce a WIDTH-bit sum plus carry-out.
// Latency: START accepted at edge E0, bit steps at E1..E_WIDTH, DONE high in the cycle after E_WIDTH.
// Backpressure: START is ignored while BUSY; a new request is accepted only in IDLE or in the DONE cycle.
//
// Ports:
//   CLK   - clock, all state updates on the rising edge
//   RST   - synchronous active-high reset, overrides everything
//   START - request, accepted only in IDLE or DONE
//   A, B  - WIDTH-bit operands, sampled on the accepting edge
//   CIN   - carry-in, sampled on the accepting edge
//   SUB   - (only with SERIAL_ADDER_SUB_EN) 1 = compute A-B, sampled on the accepting edge
//   SUM   - registered result of the last completed operation
//   COUT  - registered carry-out of the last completed operation (no-borrow flag when subtracting)
//   BUSY  - high while bit steps are in progress
//   DONE  - one-cycle pulse when SUM/COUT have just been updated
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the SUB input and two's-complement subtraction.

// Single-bit full adder used by the serial sequencer.
// Latency: purely combinational.
// Backpressure: none.
module full_adder (
  input  logic xi,
  input  logic yi,
  input  logic ci,
  output logic si,
  output logic ci1
);

  assign si  = xi ^ yi ^ ci;
  assign ci1 = (xi & yi) | (ci & (xi ^ yi));

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             BUSY,
  output logic             DONE
);

  // Bit counter only needs to reach WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // FSM decode strobes
  logic             load;
  logic             step;
  logic             finish;

  // Operand values captured on an accepting edge
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Full adder outputs for the current bit
  logic             si;
  logic             ci1;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .xi  (a_sh[0]),
    .yi  (b_sh[0]),
    .ci  (carry),
    .si  (si),
    .ci1 (ci1)
  );

  // Sum bits enter at the MSB, so after WIDTH steps bit 0 has drifted down to res_sh[0].
  assign res_next = {si, res_sh[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
  // A - B = A + ~B + 1; CIN is not used for subtraction.
  always_comb begin
    b_load = B;
    c_load = CIN;
    if (SUB) begin
      b_load = ~B;
      c_load = 1'b1;
    end
  end
`else
  always_comb begin
    b_load = B;
    c_load = CIN;
  end
`endif

  // Next-state and control decode
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          load    = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          finish  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // START here restarts immediately, giving back-to-back operations.
        if (START) begin
          load    = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register and datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      state <= state_d;
      if (load) begin
        a_sh   <= A;
        b_sh   <= b_load;
        carry  <= c_load;
        cnt    <= '0;
        res_sh <= '0;
      end else if (step) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= res_next;
        carry  <= ci1;
        cnt    <= cnt + 1'b1;
      end
      // Visible result only moves on completion; it holds through IDLE and SHIFT.
      if (finish) begin
        sum_q  <= res_next;
        cout_q <= ci1;
      end
    end
  end

  assign SUM  = sum_q;
  assign COUT = cout_q;
  assign BUSY = (state == S_SHIFT);
  assign DONE = (state == S_DONE);

endmodule
